// File: rtl/mem_phase_pkg.sv
// mem_phase_pkg: shared phase encodings, default widths and the held-request record
// for the four-phase memory sequencer.
package mem_phase_pkg;

    localparam int          ADDR_W_DEF   = 16;
    localparam int          DATA_W_DEF   = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        P_I1 = 2'd0,
        P_I2 = 2'd1,
        P_D  = 2'd2,
        P_W  = 2'd3
    } phase_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } hold_req_t;

endpackage

// File: rtl/mem_phase_ctrl_if.sv
// mem_phase_ctrl_if: core-side load/store request and response handshake.
interface mem_phase_ctrl_if
    import mem_phase_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_req_hold.sv
// mem_req_hold: single-entry request holding register; ready while empty,
// cleared when the sequencer issues the held request.
module mem_req_hold
    import mem_phase_pkg::*;
#(
    parameter type req_t = hold_req_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid_i,
    input  req_t req_i,
    input  logic issue_i,
    output logic req_ready_o,
    output logic hold_valid_o,
    output req_t held_o
);
    logic valid_q, valid_d, accept;
    req_t req_q, req_d;

    assign accept       = req_valid_i & ~valid_q;
    assign req_ready_o  = ~valid_q;
    assign hold_valid_o = valid_q;
    assign held_o       = req_q;

    always_comb begin
        valid_d = accept | (valid_q & ~issue_i);
        req_d   = accept ? req_i : req_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end
endmodule

// File: rtl/mem_phase_ctrl.sv
// mem_phase_ctrl: four-phase (I1, I2, D, W) block-RAM sequencer with one-entry core request path.
// Define MEM_STORE_ACK_EN to make stores also pulse rsp_valid.
module mem_phase_ctrl
    import mem_phase_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [ADDR_W-1:0]    pc1,
    input  logic [ADDR_W-1:0]    pc2,
    mem_phase_ctrl_if.slave      core,
    output logic                 instr_valid,
    output logic [1:0]           phase,
    output logic                 i1re,
    output logic                 i2re,
    output logic                 dre,
    output logic                 gwe,
    output logic [ADDR_W-1:0]    i1addr,
    output logic [ADDR_W-1:0]    i2addr,
    output logic [ADDR_W-1:0]    daddr,
    output logic [DATA_W-1:0]    din,
    output logic                 dwe,
    input  logic [DATA_W-1:0]    mem_dout
);
`ifdef MEM_STORE_ACK_EN
    localparam logic STORE_ACK = 1'b1;
`else
    localparam logic STORE_ACK = 1'b0;
`endif

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    phase_e            phase_q;
    logic [ADDR_W-1:0] i1addr_q, i2addr_q;
    logic              pend_q, pend_ld_q, rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              run, hold_valid, issue, frame_end;
    req_t              req_in, held;

    // Strobes are forced low while reset is asserted, not just gated by en.
    assign run         = en & rst_n;
    assign i1re        = run & (phase_q == P_I1);
    assign i2re        = run & (phase_q == P_I2);
    assign dre         = run & (phase_q == P_D);
    assign gwe         = run & (phase_q == P_W);
    assign instr_valid = dre;
    assign phase       = phase_q;
    assign frame_end   = en & (phase_q == P_W);
    assign issue       = dre & hold_valid;
    assign dwe         = issue & held.we;
    assign daddr       = held.addr;
    assign din         = held.wdata;
    assign i1addr      = i1addr_q;
    assign i2addr      = i2addr_q;
    assign req_in      = {core.req_we, core.req_addr, core.req_wdata};
    assign core.rsp_valid = rsp_valid_q;
    assign core.rsp_rdata = rsp_rdata_q;

    mem_req_hold #(.req_t(req_t)) u_hold (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (core.req_valid),
        .req_i        (req_in),
        .issue_i      (issue),
        .req_ready_o  (core.req_ready),
        .hold_valid_o (hold_valid),
        .held_o       (held)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= P_I1;
            i1addr_q    <= RESET_PC;
            i2addr_q    <= RESET_PC;
            pend_q      <= 1'b0;
            pend_ld_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (en)
                phase_q <= phase_e'(phase_q + 2'd1);
            if (frame_end) begin
                i1addr_q <= pc1;
                i2addr_q <= pc2;
            end
            // mem_dout holds its value while dre is low, so capture may wait for en.
            if (issue) begin
                pend_q    <= STORE_ACK | ~held.we;
                pend_ld_q <= ~held.we;
            end else if (frame_end && pend_q) begin
                pend_q      <= 1'b0;
                rsp_valid_q <= 1'b1;
                if (pend_ld_q)
                    rsp_rdata_q <= mem_dout;
            end
        end
    end
endmodule

// File: tb/tb_mem_phase_ctrl.sv
// tb_mem_phase_ctrl: directed and randomized checks of mem_phase_ctrl against a
// transaction-level model with a behavioural block RAM.
module tb_mem_phase_ctrl;
`ifdef MEM_STORE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } rq_t;

    logic        clk = 1'b0, rst_n, en;
    logic [15:0] pc1, pc2, mem_dout, i1addr, i2addr, daddr, din;
    logic [1:0]  phase;
    logic        instr_valid, i1re, i2re, dre, gwe, dwe;
    logic [3:0]  strb;
    logic [15:0] ram   [65536];
    logic [15:0] m_mem [65536];

    int          n_chk = 0, n_fail = 0;
    int          m_phase;
    rq_t         m_hold[$];
    logic [15:0] m_f1, m_f2, m_da, m_dd, m_rd, m_pdata;
    logic        m_rv, m_pend, m_pld;

    mem_phase_ctrl_if core ();

    mem_phase_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pc1(pc1), .pc2(pc2), .core(core),
        .instr_valid(instr_valid), .phase(phase), .i1re(i1re), .i2re(i2re),
        .dre(dre), .gwe(gwe), .i1addr(i1addr), .i2addr(i2addr), .daddr(daddr),
        .din(din), .dwe(dwe), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;
    assign strb = {gwe, dre, i2re, i1re};

    always @(posedge clk) begin
        if (dre) begin
            mem_dout <= ram[daddr];
            if (dwe) ram[daddr] <= din;
        end
    end

    task automatic model_reset();
        m_phase = 0; m_f1 = 0; m_f2 = 0; m_da = 0; m_dd = 0; m_rd = 0;
        m_rv = 0; m_pend = 0; m_pld = 0; m_pdata = 0;
        m_hold.delete();
    endtask

    // One frame-level step of the reference: fetch latch, response, issue, accept, phase.
    task automatic model_update();
        bit  acc;
        rq_t h;
        acc  = core.req_valid && m_hold.size() == 0;
        m_rv = 0;
        if (en && m_phase == 3) begin
            m_f1 = pc1; m_f2 = pc2;
            if (m_pend) begin
                m_rv = 1; m_pend = 0;
                if (m_pld) m_rd = m_pdata;
            end
        end
        if (en && m_phase == 2 && m_hold.size() != 0) begin
            h = m_hold.pop_front();
            m_pld = !h.we;
            m_pend = h.we ? ACK : 1'b1;
            if (h.we) m_mem[h.addr] = h.wdata;
            else m_pdata = m_mem[h.addr];
        end
        if (acc) begin
            m_hold.push_back('{core.req_we, core.req_addr, core.req_wdata});
            m_da = core.req_addr; m_dd = core.req_wdata;
        end
        if (en) m_phase = (m_phase + 1) % 4;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit e, input bit v, input bit w, input logic [15:0] a, input logic [15:0] d);
        en = e; core.req_valid = v; core.req_we = w; core.req_addr = a; core.req_wdata = d;
        #1;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 8 && m_phase != p; i++) begin
            drive(1, 0, 0, 0, 0);
            step();
        end
        n_chk++;
        if (m_phase != p) begin n_fail++; $display("FAIL wait_phase: reached %0d need %0d", m_phase, p); end
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        n_chk++; if (phase !== 2'd0) begin n_fail++; $display("FAIL rst_phase: got %0d exp 0", phase); end
        n_chk++; if (strb !== 4'b0 || dwe !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_strobes: got %b/%b/%b exp 0", strb, dwe, instr_valid); end
        n_chk++; if (core.req_ready !== 1'b1 || core.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hs: ready %b rsp %b exp 1/0", core.req_ready, core.rsp_valid); end
        n_chk++; if (core.rsp_rdata !== 16'h0 || daddr !== 16'h0 || din !== 16'h0) begin n_fail++; $display("FAIL rst_data: %h %h %h exp 0", core.rsp_rdata, daddr, din); end
        n_chk++; if (i1addr !== 16'h0 || i2addr !== 16'h0) begin n_fail++; $display("FAIL rst_pc: %h %h exp 0", i1addr, i2addr); end
        en = 0; rst_n = 1; #1;
        step();
    endtask

    task automatic test_phase_seq();
        pc1 = 16'h0010; pc2 = 16'h0011;
        for (int k = 0; k < 12; k++) begin
            drive(1, 0, 0, 0, 0);
            n_chk++; if (phase !== 2'(k % 4)) begin n_fail++; $display("FAIL seq_phase k=%0d: got %0d exp %0d", k, phase, k % 4); end
            n_chk++; if (strb !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL seq_strobe k=%0d: got %b exp %b", k, strb, 4'(1 << (k % 4))); end
            n_chk++; if (instr_valid !== (k % 4 == 2)) begin n_fail++; $display("FAIL seq_ivalid k=%0d: got %b", k, instr_valid); end
            n_chk++; if (i1addr !== (k < 4 ? 16'h0 : 16'h0010) || i2addr !== (k < 4 ? 16'h0 : 16'h0011)) begin n_fail++; $display("FAIL seq_fetch k=%0d: got %h/%h", k, i1addr, i2addr); end
            step();
        end
    endtask

    task automatic test_store();
        int nd = 0, nr = 0;
        wait_phase(0);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) drive(1, 1, 1, 16'h0005, 16'hBEEF);
            else drive(1, 0, 0, 0, 0);
            nd += int'(dwe); nr += int'(core.rsp_valid);
            if (k == 2) begin
                n_chk++; if (dwe !== 1'b1 || daddr !== 16'h0005 || din !== 16'hBEEF) begin n_fail++; $display("FAIL store_issue: dwe %b addr %h din %h exp 1/0005/beef", dwe, daddr, din); end
            end
            if (k == 3) begin
                n_chk++; if (core.req_ready !== 1'b1 || daddr !== 16'h0005 || din !== 16'hBEEF) begin n_fail++; $display("FAIL store_pw: ready %b addr %h din %h", core.req_ready, daddr, din); end
            end
            if (k == 1) begin
                n_chk++; if (core.req_ready !== 1'b0) begin n_fail++; $display("FAIL store_busy: ready %b exp 0", core.req_ready); end
            end
            step();
        end
        n_chk++; if (nd != 1) begin n_fail++; $display("FAIL store_dwe_count: got %0d exp 1", nd); end
        n_chk++; if (nr != int'(ACK)) begin n_fail++; $display("FAIL store_rsp_count: got %0d exp %0d", nr, ACK); end
    endtask

    task automatic test_load_in_pd();
        wait_phase(2);
        for (int k = 0; k < 10; k++) begin
            if (k == 0) drive(1, 1, 0, 16'h0005, 16'h0);
            else drive(1, 0, 0, 0, 0);
            n_chk++; if (dwe !== 1'b0) begin n_fail++; $display("FAIL load_dwe k=%0d: got %b exp 0", k, dwe); end
            n_chk++; if (core.req_ready !== (k == 0 || k >= 5)) begin n_fail++; $display("FAIL load_ready k=%0d: got %b", k, core.req_ready); end
            n_chk++; if (core.rsp_valid !== (k == 6)) begin n_fail++; $display("FAIL load_rsp k=%0d: got %b", k, core.rsp_valid); end
            if (k == 6) begin
                n_chk++; if (core.rsp_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL load_data: got %h exp beef", core.rsp_rdata); end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        rq_t a, b;
        a = '{1'b1, 16'($urandom_range(0, 15)), 16'($urandom)};
        b = '{1'b0, a.addr, 16'h0};
        wait_phase(0);
        for (int k = 0; k < 12; k++) begin
            if (k < 3) drive(1, 1, a.we, a.addr, a.wdata);
            else if (k == 3) drive(1, 1, b.we, b.addr, b.wdata);
            else drive(1, 0, 0, 0, 0);
            n_chk++; if (core.req_ready !== (k == 0 || k == 3 || k >= 7)) begin n_fail++; $display("FAIL b2b_ready k=%0d: got %b", k, core.req_ready); end
            n_chk++; if (dwe !== (k == 2)) begin n_fail++; $display("FAIL b2b_dwe k=%0d: got %b", k, dwe); end
            n_chk++; if (core.rsp_valid !== (k == 8 || (ACK && k == 4))) begin n_fail++; $display("FAIL b2b_rsp k=%0d: got %b", k, core.rsp_valid); end
            if (k == 8) begin
                n_chk++; if (core.rsp_rdata !== a.wdata) begin n_fail++; $display("FAIL b2b_data: got %h exp %h", core.rsp_rdata, a.wdata); end
            end
            step();
        end
    endtask

    task automatic test_en_stall();
        logic [15:0] r, expd;
        int np = 0;
        r = 16'($urandom_range(0, 15));
        expd = m_mem[r];
        wait_phase(0);
        for (int k = 0; k < 11; k++) begin
            if (k == 0) drive(1, 1, 0, r, 16'h0);
            else drive(!(k >= 3 && k <= 5), 0, 0, 0, 0);
            np += int'(core.rsp_valid);
            if (k >= 3 && k <= 5) begin
                n_chk++; if (phase !== 2'd3 || strb !== 4'b0) begin n_fail++; $display("FAIL stall_hold k=%0d: phase %0d strb %b exp 3/0", k, phase, strb); end
            end
            n_chk++; if (core.rsp_valid !== (k == 7)) begin n_fail++; $display("FAIL stall_rsp k=%0d: got %b", k, core.rsp_valid); end
            if (k == 7) begin
                n_chk++; if (core.rsp_rdata !== expd) begin n_fail++; $display("FAIL stall_data: got %h exp %h", core.rsp_rdata, expd); end
            end
            step();
        end
        n_chk++; if (np != 1) begin n_fail++; $display("FAIL stall_pulses: got %0d exp 1", np); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] keep;
        wait_phase(0);
        drive(1, 1, 0, 16'($urandom_range(0, 15)), 16'h0);
        step();
        drive(1, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0);
        n_chk++; if (dre !== 1'b1 || core.req_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_pre: dre %b ready %b exp 1/0", dre, core.req_ready); end
        keep = 16'h0;
        rst_n = 0; #1;
        n_chk++; if (phase !== 2'd0 || strb !== 4'b0 || dwe !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out: phase %0d strb %b dwe %b", phase, strb, dwe); end
        n_chk++; if (core.req_ready !== 1'b1 || core.rsp_valid !== 1'b0 || core.rsp_rdata !== keep || daddr !== 16'h0) begin n_fail++; $display("FAIL rmid_hs: ready %b rsp %b rdata %h daddr %h", core.req_ready, core.rsp_valid, core.rsp_rdata, daddr); end
        model_reset();
        rst_n = 1; #1;
        step();
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 0, 0, 0);
            n_chk++; if (core.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp k=%0d: got %b exp 0", k, core.rsp_valid); end
            n_chk++; if (phase !== 2'((k + 1) % 4)) begin n_fail++; $display("FAIL rmid_phase k=%0d: got %0d exp %0d", k, phase, (k + 1) % 4); end
            step();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            pc1 = 16'($urandom); pc2 = 16'($urandom);
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  16'($urandom_range(0, 15)), 16'($urandom));
            n_chk++; if (phase !== 2'(m_phase) || strb !== (en ? 4'(1 << m_phase) : 4'b0)) begin n_fail++; $display("FAIL rnd_phase k=%0d: phase %0d strb %b exp %0d", k, phase, strb, m_phase); end
            n_chk++; if (i1addr !== m_f1 || i2addr !== m_f2) begin n_fail++; $display("FAIL rnd_fetch k=%0d: %h/%h exp %h/%h", k, i1addr, i2addr, m_f1, m_f2); end
            n_chk++; if (core.req_ready !== (m_hold.size() == 0)) begin n_fail++; $display("FAIL rnd_ready k=%0d: got %b", k, core.req_ready); end
            n_chk++; if (dwe !== (en && m_phase == 2 && m_hold.size() != 0 && m_hold[0].we)) begin n_fail++; $display("FAIL rnd_dwe k=%0d: got %b", k, dwe); end
            n_chk++; if (daddr !== m_da || din !== m_dd) begin n_fail++; $display("FAIL rnd_dbus k=%0d: %h/%h exp %h/%h", k, daddr, din, m_da, m_dd); end
            n_chk++; if (core.rsp_valid !== m_rv || core.rsp_rdata !== m_rd) begin n_fail++; $display("FAIL rnd_rsp k=%0d: %b/%h exp %b/%h", k, core.rsp_valid, core.rsp_rdata, m_rv, m_rd); end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 16'(i * 7 + 16'h1234);
            m_mem[i] = 16'(i * 7 + 16'h1234);
        end
        rst_n = 0; en = 0; pc1 = 0; pc2 = 0;
        core.req_valid = 0; core.req_we = 0; core.req_addr = 0; core.req_wdata = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_phase_seq();
        test_store();
        test_load_in_pd();
        test_back_to_back();
        test_en_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_phase_ctrl.md
Name: mem_phase_ctrl

Overview:
- Four-phase memory sequencer sitting directly upstream of the shared dual-port instruction/data block RAM.
- Generates the one-hot strobes i1re, i2re, dre and gwe, plus the fetch and data addresses that go with them.
- Accepts one core load/store request through a valid/ready handshake and returns load data one frame phase after the access.
- A frame is 4 clk cycles, phases P_I1, P_I2, P_D, P_W in that order.

Parameters:
- ADDR_W, 16, address width for the fetch and data ports.
- DATA_W, 16, data word width.
- RESET_PC, 16'h0000, reset value of i1addr and i2addr.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low freezes the sequencer.
- pc1  in  ADDR_W  fetch address for slot 1 of the next frame.
- pc2  in  ADDR_W  fetch address for slot 2 of the next frame.
- req_valid  in  1  core data request valid.
- req_ready  out  1  request accepted when high together with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  data address of the request.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle pulse marking a load response.
- rsp_rdata  out  DATA_W  load response data.
- instr_valid  out  1  both fetched instructions are readable from the RAM this cycle.
- phase  out  2  current phase: 0 = P_I1, 1 = P_I2, 2 = P_D, 3 = P_W.
- i1re, i2re, dre, gwe  out  1  each  RAM strobes, one-hot.
- i1addr, i2addr  out  ADDR_W  each  RAM fetch addresses.
- daddr  out  ADDR_W  RAM data address.
- din  out  DATA_W  RAM write data.
- dwe  out  1  RAM write enable.
- mem_dout  in  DATA_W  RAM data read output, registered inside the RAM.

Behaviour:
- Reset values: phase = P_I1; i1addr = i2addr = RESET_PC; hold register empty; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; daddr = din = 0.
  - All strobes, dwe and instr_valid are 0 during reset.
- Phase counter:
  - When en = 1, phase advances by one every cycle, with P_W wrapping to P_I1.
  - When en = 0, phase holds its value.
- Strobes are combinational from phase and en: i1re = en & (phase == P_I1), and likewise i2re for P_I2, dre for P_D, gwe for P_W.
  - Exactly one strobe is high when en = 1; none is high when en = 0.
- Fetch addresses: i1addr and i2addr are registered from pc1 and pc2 on the P_W -> P_I1 advance, then held stable for the whole frame.
- instr_valid = en & (phase == P_D).
- Hold register (one entry):
  - req_ready = !hold_valid.
  - On req_valid & req_ready, the block latches req_we, req_addr and req_wdata and sets hold_valid.
  - A request is accepted in any phase, including P_D.
- Issue:
  - A held request issues only in a P_D cycle with en = 1 where hold_valid was already set at the start of that cycle.
  - A request accepted during P_D waits for the next frame.
  - daddr and din are driven from the hold register and stay stable from P_D through P_W.
  - dwe = en & (phase == P_D) & issuing & held_we, so a store writes exactly once.
  - hold_valid clears at the end of the issuing P_D cycle, so req_ready rises in P_W.
- Load response:
  - The RAM output is valid during P_W.
  - On the P_W -> P_I1 advance after an issued load, rsp_rdata <= mem_dout and rsp_valid pulses high for exactly the following cycle (P_I1).
  - rsp_rdata holds its value until the next load.
  - Load-to-response latency is 2 cycles after the issuing P_D cycle, assuming en stays high.
- en drop during P_W with a load pending: capture is deferred until the advance; mem_dout stays stable because dre is low.
- Asynchronous reset mid-frame: a pending or issued request is dropped, no rsp_valid is produced, and the sequencer restarts at P_I1.
- Back-to-back requests: the maximum rate is one per frame; req_ready back-pressures anything faster.

Optional Feature:
- MEM_STORE_ACK_EN defined: stores also produce a rsp_valid pulse in the same cycle a load would (P_I1 of the next frame), and rsp_rdata is left unchanged.
- MEM_STORE_ACK_EN undefined: stores produce no response; only loads pulse rsp_valid.

Decomposition:
- Package mem_phase_pkg holds:
  - phase encodings P_I1, P_I2, P_D, P_W;
  - default ADDR_W, DATA_W and RESET_PC constants;
  - a struct typedef for the held request {we, addr, wdata}.
- One natural sub-module, mem_req_hold: the single-entry hold register with its valid/ready logic and clear-on-issue.
- The phase counter, strobe decode and response capture stay in the top module.

Test Plan:
- Reset, then en = 1 with pc1 = 16'h0010, pc2 = 16'h0011 -> strobe sequence i1re, i2re, dre, gwe repeats every 4 cycles; the first frame fetches 16'h0000 / 16'h0000, the second 16'h0010 / 16'h0011; instr_valid is high only in P_D.
- Store req_addr = 16'h0005, req_wdata = 16'hBEEF accepted in P_I1 -> in the same frame's P_D: dwe = 1, daddr = 16'h0005, din = 16'hBEEF, for one cycle only; no rsp_valid (ack pulse instead when MEM_STORE_ACK_EN is defined).
- Load from 16'h0005 accepted in P_D -> not issued until the next frame's P_D; rsp_valid pulses in the following P_I1 with rsp_rdata = 16'hBEEF.
- Two back-to-back requests with req_valid held high -> req_ready is low from acceptance until P_W of the issuing frame; the second request issues one frame later.
- en = 0 for 3 cycles during P_W with a load pending -> phase holds at 3, all strobes are 0; after en returns, the response arrives with the correct data and no duplicate pulse.
- rst_n asserted during P_D while a load is issuing -> all outputs return to reset values immediately; no rsp_valid follows; the sequencer resumes at P_I1.
